// File: rtl/access_pkg.sv
// Shared definitions for the multi-lab access controller: request modes,
// card parity and default occupancy limits.
package access_pkg;

  typedef enum logic [1:0] {
    MODE_EXIT  = 2'b00,
    MODE_ENTER = 2'b01,
    MODE_XFER  = 2'b10,
    MODE_IDLE  = 2'b11
  } mode_e;

  localparam int unsigned DEFAULT_CAP         = 30;
  localparam int unsigned DEFAULT_RESTRICT_AT = 15;

  // Zero-extension does not change the XOR-reduction, so any code width up to 32 fits.
  function automatic logic parity(input logic [31:0] code);
    return ^code;
  endfunction

endpackage

// File: rtl/lab_slot.sv
// One lab door: occupancy counter, unlock hold timer and the admit/warn
// decision for a request targeting this lab.
module lab_slot
  import access_pkg::*;
#(
  parameter int unsigned CAP         = DEFAULT_CAP,
  parameter int unsigned RESTRICT_AT = DEFAULT_RESTRICT_AT,
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned UNLOCK_HOLD = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             inc,
  input  logic             dec,
  input  logic             parityPass,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             unlock,
  output logic             admit,
  output logic             warn
);

  localparam int unsigned TMR_W = $clog2(UNLOCK_HOLD + 1);

  logic [CNT_W-1:0] countQ, countD;
  logic [TMR_W-1:0] timerQ, timerD;
  logic             restricted;

  always_comb begin
    countD = countQ;
    if (inc && !dec) begin
      countD = countQ + CNT_W'(1);
    end else if (dec && !inc) begin
      countD = countQ - CNT_W'(1);
    end
    // Any grant on this door (re)starts the hold, otherwise count down to zero.
    if (inc || dec) begin
      timerD = TMR_W'(UNLOCK_HOLD);
    end else if (timerQ != '0) begin
      timerD = timerQ - TMR_W'(1);
    end else begin
      timerD = timerQ;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      countQ <= '0;
      timerQ <= '0;
    end else begin
      countQ <= countD;
      timerQ <= timerD;
    end
  end

  assign count      = countQ;
  assign full       = (countQ == CNT_W'(CAP));
  assign empty      = (countQ == '0);
  assign unlock     = (timerQ != '0);
  assign restricted = (countQ >= CNT_W'(RESTRICT_AT));
  // A full lab refuses silently; only the parity rule raises a warning.
  assign admit      = !full && (!restricted || parityPass);
  assign warn       = !full && restricted && !parityPass;

endmodule

// File: rtl/multi_lab_access_ctrl.sv
// Access controller for NUM_LABS lab doors: decodes one enter/exit/transfer
// card request per clock and drives per-door unlock, warning and occupancy flags.
module multi_lab_access_ctrl
  import access_pkg::*;
#(
  parameter int unsigned          NUM_LABS    = 4,
  parameter int unsigned          LAB_W       = 2,
  parameter int unsigned          CODE_W      = 5,
  parameter int unsigned          CAP         = DEFAULT_CAP,
  parameter int unsigned          RESTRICT_AT = DEFAULT_RESTRICT_AT,
  parameter int unsigned          CNT_W       = 6,
  parameter logic [NUM_LABS-1:0]  PARITY_ODD  = 4'b0101,
  parameter int unsigned          UNLOCK_HOLD = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [CODE_W-1:0]         smartCode,
  input  logic [1:0]                mode,
  input  logic [LAB_W-1:0]          labSel,
  input  logic [LAB_W-1:0]          dstSel,
  output logic [NUM_LABS*CNT_W-1:0] numOfStu,
  output logic [NUM_LABS-1:0]       unlock,
  output logic [NUM_LABS-1:0]       restrictionWarn,
  output logic [NUM_LABS-1:0]       isFull,
  output logic [NUM_LABS-1:0]       isEmpty,
  output logic                      badReq
);

  logic                codeParity;
  logic                srcOk, dstOk;
  logic [NUM_LABS-1:0] admit, warnIf;
  logic [NUM_LABS-1:0] incReq, decReq, warnNext;
  logic                badNext;
  logic [NUM_LABS-1:0] warnQ;
  logic                badQ;

  assign codeParity = parity(32'(smartCode));
  assign srcOk      = (32'(labSel) < NUM_LABS);
  assign dstOk      = (32'(dstSel) < NUM_LABS);

  for (genvar i = 0; i < NUM_LABS; i++) begin : gSlot
    lab_slot #(
      .CAP         (CAP),
      .RESTRICT_AT (RESTRICT_AT),
      .CNT_W       (CNT_W),
      .UNLOCK_HOLD (UNLOCK_HOLD)
    ) uSlot (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .inc        (incReq[i]),
      .dec        (decReq[i]),
      .parityPass (codeParity == PARITY_ODD[i]),
      .count      (numOfStu[i*CNT_W +: CNT_W]),
      .full       (isFull[i]),
      .empty      (isEmpty[i]),
      .unlock     (unlock[i]),
      .admit      (admit[i]),
      .warn       (warnIf[i])
    );
  end

  always_comb begin
    incReq   = '0;
    decReq   = '0;
    warnNext = '0;
    badNext  = 1'b0;
    case (mode_e'(mode))
      MODE_EXIT: begin
        if (!srcOk) begin
          badNext = 1'b1;
        end else if (!isEmpty[labSel]) begin
          decReq[labSel] = 1'b1;
        end
      end
      MODE_ENTER: begin
        if (!srcOk) begin
          badNext = 1'b1;
        end else if (admit[labSel]) begin
          incReq[labSel] = 1'b1;
        end else if (warnIf[labSel]) begin
          warnNext[labSel] = 1'b1;
        end
      end
      MODE_XFER: begin
        if (!srcOk || !dstOk || (labSel == dstSel)) begin
          badNext = 1'b1;
        end else if (!isEmpty[labSel]) begin
          // Source and destination move together at the same edge, or not at all.
          if (admit[dstSel]) begin
            decReq[labSel] = 1'b1;
            incReq[dstSel] = 1'b1;
          end else if (warnIf[dstSel]) begin
            warnNext[dstSel] = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      warnQ <= '0;
      badQ  <= 1'b0;
    end else begin
      warnQ <= warnNext;
      badQ  <= badNext;
    end
  end

  assign restrictionWarn = warnQ;
  assign badReq          = badQ;

endmodule

// File: tb/tb_multi_lab_access_ctrl.sv
// Scoreboard bench: two controllers (hold 1 and hold 4) share one request stream;
// a lab-level model predicts each cycle's outputs and a monitor compares them.
module tb_multi_lab_access_ctrl;

  localparam int CAPV = 30;
  localparam int RA   = 15;
  localparam logic [3:0] PODD = 4'b0101;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [4:0]  smartCode;
  logic [1:0]  mode;
  logic [1:0]  labSel, dstSel;

  logic [23:0] numA, numB;
  logic [3:0]  ulA, ulB, warnA, warnB, fullA, fullB, emptyA, emptyB;
  logic        badA, badB;

  always #5 CLK = ~CLK;

  multi_lab_access_ctrl dutA (
    .CLK(CLK), .RST_N(RST_N), .smartCode(smartCode), .mode(mode), .labSel(labSel),
    .dstSel(dstSel), .numOfStu(numA), .unlock(ulA), .restrictionWarn(warnA),
    .isFull(fullA), .isEmpty(emptyA), .badReq(badA)
  );

  multi_lab_access_ctrl #(.UNLOCK_HOLD(4)) dutB (
    .CLK(CLK), .RST_N(RST_N), .smartCode(smartCode), .mode(mode), .labSel(labSel),
    .dstSel(dstSel), .numOfStu(numB), .unlock(ulB), .restrictionWarn(warnB),
    .isFull(fullB), .isEmpty(emptyB), .badReq(badB)
  );

  typedef struct packed {
    logic [23:0] cnt;
    logic [3:0]  ul1, ul4, warn, full, empty;
    logic        bad;
  } exp_t;

  exp_t sbq[$];
  exp_t eCur;
  bit   monOn = 0;
  int   checks = 0;
  int   errors = 0;

  int cnt[4];
  int t1[4];
  int t4[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic bit labPass(input int l, input int c, input bit p);
    if (c < RA) return 1'b1;
    if (c >= CAPV) return 1'b0;
    return p == PODD[l];
  endfunction

  function automatic bit labWarn(input int l, input int c, input bit p);
    return (c >= RA) && (c < CAPV) && (p != PODD[l]);
  endfunction

  task automatic grant(input int l);
    t1[l] = 1;
    t4[l] = 4;
  endtask

  function automatic exp_t snapshot(input logic [3:0] w, input logic b);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.cnt[i*6 +: 6] = 6'(cnt[i]);
      e.ul1[i]   = (t1[i] != 0);
      e.ul4[i]   = (t4[i] != 0);
      e.full[i]  = (cnt[i] == CAPV);
      e.empty[i] = (cnt[i] == 0);
    end
    e.warn = w;
    e.bad  = b;
    return e;
  endfunction

  // Drive one request at the falling edge and queue what the next rising edge must show.
  task automatic step(input logic [4:0] c, input logic [1:0] m, input int l, input int d);
    logic [3:0] w;
    logic       b;
    bit         p;
    @(negedge CLK);
    smartCode = c;
    mode      = m;
    labSel    = 2'(l);
    dstSel    = 2'(d);
    p = ^c;
    w = '0;
    b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (t1[i] > 0) t1[i]--;
      if (t4[i] > 0) t4[i]--;
    end
    case (m)
      2'b00: if (cnt[l] > 0) begin cnt[l]--; grant(l); end
      2'b01: begin
        if (labPass(l, cnt[l], p)) begin cnt[l]++; grant(l); end
        else if (labWarn(l, cnt[l], p)) w[l] = 1'b1;
      end
      2'b10: begin
        if (l == d) b = 1'b1;
        else if (cnt[l] > 0) begin
          if (labPass(d, cnt[d], p)) begin
            cnt[l]--; cnt[d]++; grant(l); grant(d);
          end else if (labWarn(d, cnt[d], p)) w[d] = 1'b1;
        end
      end
      default: ;
    endcase
    sbq.push_back(snapshot(w, b));
    monOn = 1;
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_num"},   32'(numA),   0);
    chk({tag, "_numB"},  32'(numB),   0);
    chk({tag, "_ul"},    32'(ulA),    0);
    chk({tag, "_ulB"},   32'(ulB),    0);
    chk({tag, "_warn"},  32'(warnA),  0);
    chk({tag, "_bad"},   32'(badA),   0);
    chk({tag, "_empty"}, 32'(emptyA), 32'hf);
    chk({tag, "_full"},  32'(fullA),  0);
  endtask

  always @(posedge CLK) begin
    if (monOn) begin
      #1;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow got=empty want=entry at %0t", $time);
      end else begin
        eCur = sbq.pop_front();
        chk("num",    32'(numA),   32'(eCur.cnt));
        chk("numB",   32'(numB),   32'(eCur.cnt));
        chk("ul1",    32'(ulA),    32'(eCur.ul1));
        chk("ul4",    32'(ulB),    32'(eCur.ul4));
        chk("warn",   32'(warnA),  32'(eCur.warn));
        chk("warnB",  32'(warnB),  32'(eCur.warn));
        chk("full",   32'(fullA),  32'(eCur.full));
        chk("empty",  32'(emptyA), 32'(eCur.empty));
        chk("bad",    32'(badA),   32'(eCur.bad));
        chk("badB",   32'(badB),   32'(eCur.bad));
      end
    end
  end

  initial begin
    RST_N = 1'b0;
    smartCode = '0;
    mode = 2'b11;
    labSel = '0;
    dstSel = '0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; t1[i] = 0; t4[i] = 0; end
    #3;
    chkReset("rst0");
    @(negedge CLK);
    RST_N = 1'b1;

    // Fill lab0 to 16 with an odd code.
    for (int i = 0; i < 16; i++) step(5'b00001, 2'b01, 0, 0);
    settle();
    chk("cnt0_16", 32'(numA[5:0]), 16);
    chk("empty0_low", 32'(emptyA[0]), 0);

    // Lab1 to 15 with even codes, then the parity refusal and the retry.
    for (int i = 0; i < 15; i++) step(5'b00000, 2'b01, 1, 0);
    step(5'b00001, 2'b01, 1, 0);
    settle();
    chk("warn1", 32'(warnA), 32'b0010);
    chk("cnt1_15", 32'(numA[11:6]), 15);
    step(5'b00011, 2'b01, 1, 0);
    settle();
    chk("cnt1_16", 32'(numA[11:6]), 16);
    chk("ul1_retry", 32'(ulA[1]), 1);

    // Lab0 to capacity, a refused entry, and an exit from an empty lab.
    for (int i = 0; i < 14; i++) step(5'b00001, 2'b01, 0, 0);
    step(5'b00001, 2'b01, 0, 0);
    settle();
    chk("full0", 32'(fullA[0]), 1);
    chk("full0_noul", 32'(ulA), 0);
    step(5'b00000, 2'b00, 2, 0);
    settle();
    chk("empty2", 32'(emptyA[2]), 1);

    // Transfer 0 -> 3 from counts 5 and 2, then a self-transfer.
    for (int i = 0; i < 25; i++) step(5'b00000, 2'b00, 0, 0);
    step(5'b00000, 2'b01, 3, 0);
    step(5'b00000, 2'b01, 3, 0);
    step(5'b00000, 2'b10, 0, 3);
    settle();
    chk("xfer_cnt0", 32'(numA[5:0]), 4);
    chk("xfer_cnt3", 32'(numA[23:18]), 3);
    chk("xfer_ul", 32'(ulA), 32'b1001);
    step(5'b00000, 2'b10, 2, 2);
    settle();
    chk("self_bad", 32'(badA), 1);

    // Overlapping grants on lab2 stretch the 4-cycle hold.
    step(5'b00000, 2'b01, 2, 0);
    step(5'b00000, 2'b11, 0, 0);
    step(5'b00000, 2'b01, 2, 0);
    for (int i = 0; i < 6; i++) step(5'b00000, 2'b11, 0, 0);

    // Asynchronous reset in the middle of a hold.
    step(5'b00000, 2'b01, 2, 0);
    step(5'b00000, 2'b11, 0, 0);
    settle();
    chk("prerst_ulB", 32'(ulB[2]), 1);
    monOn = 0;
    #4;
    RST_N = 1'b0;
    #1;
    chkReset("rst_async");
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; t1[i] = 0; t4[i] = 0; end
    @(negedge CLK);
    RST_N = 1'b1;

    // Random traffic biased towards entries so the restricted band is exercised.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [1:0] m;
      r = $urandom_range(0, 9);
      m = (r < 5) ? 2'b01 : (r < 7) ? 2'b00 : (r < 9) ? 2'b10 : 2'b11;
      step(5'($urandom), m, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    settle();
    monOn = 0;
    chk("sb_drained", 32'(sbq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
